fwd_sel_ctrl: RTL and testbench

//   Drives the 2-bit select inputs of the two EX-stage Mux3 operand muxes.

---
 rtl/fwd_sel_ctrl.sv | 116 +++++++++++
 tb/tb_fwd_sel_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: EX-stage operand forwarding selects and load-use stall request.
// Tracks destination tags of the instructions in EX and MEM. Selects for the
// instruction entering EX are computed one edge ahead, so the muxes see flops.
module fwd_sel_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ext_stall,
    input  logic             id_flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_wen,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             id_mem_read,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             load_use_stall
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;  // EX/MEM result
    localparam logic [1:0] SEL_WB  = 2'b10;  // MEM/WB result

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] wreg;
        logic             mem_read;
    } slot_t;

    // The EX slot needs mem_read for the load-use check. The MEM slot only has to
    // answer "does it write r". The WB tag is not stored at all: the regfile
    // writes through, so nothing ever reads it.
    slot_t            ex_q, ex_d;
    logic             mem_vld_q, mem_vld_d;
    logic             mem_wen_q, mem_wen_d;
    logic [REG_W-1:0] mem_wreg_q, mem_wreg_d;
    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;

    // A live tag that writes r. r0 is hardwired zero and is never forwarded.
    function automatic logic writes(input logic v, input logic w,
                                    input logic [REG_W-1:0] wreg,
                                    input logic [REG_W-1:0] r);
        return v && w && (wreg == r) && (r != '0);
    endfunction

    // Select for one source operand of the ID instruction. EX wins over MEM (younger).
    function automatic logic [1:0] pick(input logic used, input logic [REG_W-1:0] r);
        if (!id_valid || !used)                          return SEL_RF;
        if (writes(ex_q.valid, ex_q.wen, ex_q.wreg, r))  return SEL_MEM;
        if (writes(mem_vld_q, mem_wen_q, mem_wreg_q, r)) return SEL_WB;
        return SEL_RF;
    endfunction

    // Load in EX feeding ID: hold IF/ID one cycle. A flushed ID instruction never stalls.
    always_comb begin
        load_use_stall = !id_flush && id_valid && ex_q.valid && ex_q.wen && ex_q.mem_read
                      && (ex_q.wreg != '0)
                      && ((id_rs_used && ex_q.wreg == id_rs) || (id_rt_used && ex_q.wreg == id_rt));
    end

    // Next tag slots and selects: freeze, bubble, or advance.
    always_comb begin
        ex_d       = ex_q;
        mem_vld_d  = mem_vld_q;
        mem_wen_d  = mem_wen_q;
        mem_wreg_d = mem_wreg_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        if (!ext_stall) begin
            mem_vld_d  = ex_q.valid;
            mem_wen_d  = ex_q.wen;
            mem_wreg_d = ex_q.wreg;
            if (id_flush || load_use_stall) begin
                ex_d    = '0;
                sel_a_d = SEL_RF;
                sel_b_d = SEL_RF;
            end else begin
                ex_d.valid    = id_valid;
                ex_d.wen      = id_wen;
                ex_d.wreg     = id_wreg;
                ex_d.mem_read = id_mem_read;
                sel_a_d       = pick(id_rs_used, id_rs);
                sel_b_d       = pick(id_rt_used, id_rt);
            end
        end
    end

    // State registers; reset drops every tag at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_q       <= '0;
            mem_vld_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_wreg_q <= '0;
            sel_a_q    <= SEL_RF;
            sel_b_q    <= SEL_RF;
        end else begin
            ex_q       <= ex_d;
            mem_vld_q  <= mem_vld_d;
            mem_wen_q  <= mem_wen_d;
            mem_wreg_q <= mem_wreg_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: hand-computed selects/stall per step.
module tb_fwd_sel_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ext_stall, id_flush, id_valid;
    logic [4:0] id_rs, id_rt, id_wreg;
    logic       id_rs_used, id_rt_used, id_wen, id_mem_read;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       load_use_stall;

    int total = 0;
    int bad   = 0;

    fwd_sel_ctrl #(.REG_W(5)) dut (
        .clk(clk), .resetn(resetn), .ext_stall(ext_stall), .id_flush(id_flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wen(id_wen),
        .id_wreg(id_wreg), .id_mem_read(id_mem_read),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Put an instruction in ID: valid, rs, rt, rs_used, rt_used, wen, wreg, load.
    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ru, input logic tu, input logic w,
                         input logic [4:0] wr, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
        id_wen = w; id_wreg = wr; id_mem_read = ld;
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push bubbles until EX and MEM hold nothing.
    task automatic drain();
        nop();
        tick(); tick(); tick();
    endtask

    initial begin
        resetn = 1'b0; ext_stall = 1'b0; id_flush = 1'b0;
        nop();
        chk("rst_sel_a", fwd_sel_a, 2'b00);
        chk("rst_sel_b", fwd_sel_b, 2'b00);
        chk("rst_stall", {1'b0, load_use_stall}, 2'b00);
        tick();
        resetn = 1'b1;
        tick();

        // back-to-back: addu r3<-r1,r2 ; addu r4<-r3,r3
        issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        tick();
        issue(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0);
        chk("b2b_nostall", {1'b0, load_use_stall}, 2'b00);
        tick();
        chk("b2b_sel_a", fwd_sel_a, 2'b01);
        chk("b2b_sel_b", fwd_sel_b, 2'b01);
        // freeze 3 cycles with a consumer of r4 (rs) and r3 (rt) waiting in ID
        issue(1, 5'd4, 5'd3, 1, 1, 0, 5'd0, 0);
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_sel_a", fwd_sel_a, 2'b01);
            chk("frz_sel_b", fwd_sel_b, 2'b01);
        end
        ext_stall = 1'b0;
        tick();
        // frozen tags: EX still addu r4, MEM still addu r3
        chk("unfrz_sel_a", fwd_sel_a, 2'b01);
        chk("unfrz_sel_b", fwd_sel_b, 2'b10);
        drain();

        // addu r3 ; nop ; subu r5<-r3,r6
        issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        tick();
        nop();
        tick();
        issue(1, 5'd3, 5'd6, 1, 1, 1, 5'd5, 0);
        tick();
        chk("gap_sel_a", fwd_sel_a, 2'b10);
        chk("gap_sel_b", fwd_sel_b, 2'b00);
        drain();
        // same with r0 as destination
        issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0);
        tick();
        nop();
        tick();
        issue(1, 5'd0, 5'd6, 1, 1, 1, 5'd5, 0);
        tick();
        chk("r0_sel_a", fwd_sel_a, 2'b00);
        chk("r0_sel_b", fwd_sel_b, 2'b00);
        drain();

        // lw r7 ; addu r9<-r7,r1
        issue(1, 5'd2, 5'd0, 1, 0, 1, 5'd7, 1);
        tick();
        issue(1, 5'd7, 5'd1, 1, 1, 1, 5'd9, 0);
        chk("lu_stall", {1'b0, load_use_stall}, 2'b01);
        tick();
        chk("lu_bub_sel_a", fwd_sel_a, 2'b00);
        chk("lu_bub_sel_b", fwd_sel_b, 2'b00);
        chk("lu_stall_once", {1'b0, load_use_stall}, 2'b00);
        tick();
        chk("lu_sel_a", fwd_sel_a, 2'b10);
        chk("lu_sel_b", fwd_sel_b, 2'b00);
        drain();
        // same, with ID flushed while the load is in EX
        issue(1, 5'd2, 5'd0, 1, 0, 1, 5'd7, 1);
        tick();
        issue(1, 5'd7, 5'd1, 1, 1, 1, 5'd9, 0);
        id_flush = 1'b1;
        #1;
        chk("fl_nostall", {1'b0, load_use_stall}, 2'b00);
        tick();
        id_flush = 1'b0;
        #1;
        chk("fl_sel_a", fwd_sel_a, 2'b00);
        chk("fl_bubble_in_ex", {1'b0, load_use_stall}, 2'b00);
        drain();

        // lw r3 (MEM) and addu r3 (EX): younger wins
        issue(1, 5'd1, 5'd0, 1, 0, 1, 5'd3, 1);
        tick();
        issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        tick();
        issue(1, 5'd3, 5'd3, 1, 1, 1, 5'd10, 0);
        chk("yw_nostall", {1'b0, load_use_stall}, 2'b00);
        tick();
        chk("yw_sel_a", fwd_sel_a, 2'b01);
        chk("yw_sel_b", fwd_sel_b, 2'b01);
        drain();

        // reset mid-stream with lw r8 pending in EX
        issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        tick();
        issue(1, 5'd3, 5'd0, 1, 0, 1, 5'd8, 1);
        tick();
        issue(1, 5'd8, 5'd0, 1, 0, 1, 5'd11, 0);
        chk("pre_rst_sel_a", fwd_sel_a, 2'b01);
        chk("pre_rst_stall", {1'b0, load_use_stall}, 2'b01);
        resetn = 1'b0;
        #1;
        chk("mid_rst_sel_a", fwd_sel_a, 2'b00);
        chk("mid_rst_sel_b", fwd_sel_b, 2'b00);
        chk("mid_rst_stall", {1'b0, load_use_stall}, 2'b00);
        resetn = 1'b1;
        #1;
        chk("post_rst_stall", {1'b0, load_use_stall}, 2'b00);
        tick();
        chk("post_rst_sel_a", fwd_sel_a, 2'b00);
        chk("post_rst_sel_b", fwd_sel_b, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
